// File: rtl/sat_stat.sv
// Power-of-two saturator with per-sample clamp flags, sticky flags and a saturating event counter.
// Latency: 1 cycle from in/in_valid to out/out_valid/pos_sat/neg_sat; statistics update on the same edge.
// Backpressure: none; a sample is accepted every cycle in_valid is high, and out holds while in_valid is low.
module sat_stat #(
  parameter int RES  = 14,
  parameter int LW   = 4,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [RES-1:0]  in,
  input  logic [LW-1:0]   lim,
  input  logic            sym,
  input  logic            clr,
  output logic [RES-1:0]  out,
  output logic            out_valid,
  output logic            pos_sat,
  output logic            neg_sat,
  output logic            sticky_pos,
  output logic            sticky_neg,
  output logic [CNTW-1:0] sat_cnt
);

  // Largest usable exponent: 2^(RES-1)-1 is the top of the signed range.
  localparam logic [LW-1:0]   EMAX    = LW'(RES - 1);
  localparam logic [CNTW-1:0] CNT_TOP = {CNTW{1'b1}};

  logic [LW-1:0]   w_e;
  logic [RES-1:0]  w_pow;
  logic [RES-1:0]  w_max;
  logic [RES-1:0]  w_min;
  logic            w_pos;
  logic            w_neg;
  logic [RES-1:0]  w_out;
  logic [CNTW-1:0] w_cnt_base;
  logic            w_spos_base;
  logic            w_sneg_base;

  logic [RES-1:0]  r_out;
  logic            r_out_valid;
  logic            r_pos_sat;
  logic            r_neg_sat;
  logic            r_sticky_pos;
  logic            r_sticky_neg;
  logic [CNTW-1:0] r_sat_cnt;

  // Derive the clamp bounds from the live limit registers and clamp the sample.
  // At e = RES-1 the pow value wraps to the most negative code, which is exactly
  // the full-range minimum, and pow-1 is the full-range maximum.
  always_comb begin
    w_e   = (lim > EMAX) ? EMAX : lim;
    w_pow = RES'(1) << w_e;
    w_max = w_pow - RES'(1);
    w_min = sym ? (RES'(0) - w_max) : (RES'(0) - w_pow);
    w_pos = $signed(in) > $signed(w_max);
    w_neg = $signed(in) < $signed(w_min);
    w_out = in;
    if (w_pos) begin
      w_out = w_max;
    end else if (w_neg) begin
      w_out = w_min;
    end
  end

  // Clear takes effect first so an event in the same cycle is counted after it.
  always_comb begin
    w_cnt_base  = clr ? '0 : r_sat_cnt;
    w_spos_base = clr ? 1'b0 : r_sticky_pos;
    w_sneg_base = clr ? 1'b0 : r_sticky_neg;
  end

  // Output register stage: hold the last sample when no valid input arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_pos_sat   <= 1'b0;
      r_neg_sat   <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      r_pos_sat   <= in_valid & w_pos;
      r_neg_sat   <= in_valid & w_neg;
      if (in_valid) begin
        r_out <= w_out;
      end
    end
  end

  // Host statistics: sticky flags and a non-wrapping clamp-event counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sticky_pos <= 1'b0;
      r_sticky_neg <= 1'b0;
      r_sat_cnt    <= '0;
    end else begin
      r_sticky_pos <= w_spos_base | (in_valid & w_pos);
      r_sticky_neg <= w_sneg_base | (in_valid & w_neg);
      if (in_valid && (w_pos || w_neg) && (w_cnt_base != CNT_TOP)) begin
        r_sat_cnt <= w_cnt_base + CNTW'(1);
      end else begin
        r_sat_cnt <= w_cnt_base;
      end
    end
  end

  assign out        = r_out;
  assign out_valid  = r_out_valid;
  assign pos_sat    = r_pos_sat;
  assign neg_sat    = r_neg_sat;
  assign sticky_pos = r_sticky_pos;
  assign sticky_neg = r_sticky_neg;
  assign sat_cnt    = r_sat_cnt;

endmodule

// File: tb/tb_sat_stat.sv
module tb_sat_stat;

  localparam int RES  = 14;
  localparam int LW   = 4;
  localparam int CNTW = 4;
  localparam int CMAX = (1 << CNTW) - 1;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic [RES-1:0]  in;
  logic [LW-1:0]   lim;
  logic            sym;
  logic            clr;
  logic [RES-1:0]  out;
  logic            out_valid;
  logic            pos_sat;
  logic            neg_sat;
  logic            sticky_pos;
  logic            sticky_neg;
  logic [CNTW-1:0] sat_cnt;

  sat_stat #(.RES(RES), .LW(LW), .CNTW(CNTW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in         (in),
    .lim        (lim),
    .sym        (sym),
    .clr        (clr),
    .out        (out),
    .out_valid  (out_valid),
    .pos_sat    (pos_sat),
    .neg_sat    (neg_sat),
    .sticky_pos (sticky_pos),
    .sticky_neg (sticky_neg),
    .sat_cnt    (sat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit v;
    int x;
    int l;
    bit s;
    bit c;
    int eo;
    bit ep;
    bit en;
  } vec_t;

  typedef struct {
    bit vld;
    int o;
    bit p;
    bit n;
    bit sp;
    bit sn;
    int cnt;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  // bench-side state of the reference model
  int m_out = 0;
  int m_cnt = 0;
  bit m_sp  = 0;
  bit m_sn  = 0;

  function automatic void chk(string name, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endfunction

  // independent clamp reference using plain integer arithmetic
  function automatic void clamp(input int x, input int l, input bit s,
                                output int o, output bit p, output bit n);
    int e, mx, mn;
    e  = (l > RES - 1) ? RES - 1 : l;
    mx = (1 << e) - 1;
    mn = s ? -mx : -(1 << e);
    p  = x > mx;
    n  = x < mn;
    o  = p ? mx : (n ? mn : x);
  endfunction

  task automatic step(input string name, input bit v, input int x, input int l,
                      input bit s, input bit c, input bit r,
                      input int eo, input bit ep, input bit en);
    exp_t e;
    exp_t got;
    @(negedge clk);
    in_valid = v;
    in       = RES'(x);
    lim      = LW'(l);
    sym      = s;
    clr      = c;
    rst      = r;
    if (r) begin
      m_out = 0; m_cnt = 0; m_sp = 0; m_sn = 0;
      e = '{vld: 0, o: 0, p: 0, n: 0, sp: 0, sn: 0, cnt: 0};
    end else begin
      if (c) begin
        m_cnt = 0; m_sp = 0; m_sn = 0;
      end
      if (v) begin
        m_out = eo;
        if (ep || en) m_cnt = (m_cnt == CMAX) ? CMAX : m_cnt + 1;
        m_sp = m_sp | ep;
        m_sn = m_sn | en;
      end
      e = '{vld: v, o: m_out, p: v & ep, n: v & en, sp: m_sp, sn: m_sn, cnt: m_cnt};
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({name, ".scoreboard_empty"}, 1, 0);
    end else begin
      got = sb.pop_front();
      chk({name, ".out"},        $signed(out), got.o);
      chk({name, ".out_valid"},  int'(out_valid), int'(got.vld));
      chk({name, ".pos_sat"},    int'(pos_sat), int'(got.p));
      chk({name, ".neg_sat"},    int'(neg_sat), int'(got.n));
      chk({name, ".sticky_pos"}, int'(sticky_pos), int'(got.sp));
      chk({name, ".sticky_neg"}, int'(sticky_neg), int'(got.sn));
      chk({name, ".sat_cnt"},    int'(sat_cnt), got.cnt);
    end
  endtask

  task automatic auto_step(input string name, input bit v, input int x, input int l,
                           input bit s, input bit c, input bit r);
    int o;
    bit p, n;
    clamp(x, l, s, o, p, n);
    step(name, v, x, l, s, c, r, o, p, n);
  endtask

  vec_t tbl[$];

  initial begin
    // hand-derived vectors: v, in, lim, sym, clr, exp_out, exp_pos, exp_neg
    tbl.push_back('{1,   100,  4, 0, 0,    15, 1, 0});
    tbl.push_back('{1,  -100,  4, 0, 0,   -16, 0, 1});
    tbl.push_back('{1,  -100,  4, 1, 0,   -15, 0, 1});
    tbl.push_back('{1,   -16,  4, 1, 0,   -15, 0, 1});
    tbl.push_back('{1,   -16,  4, 0, 0,   -16, 0, 0});
    tbl.push_back('{1,    15,  4, 0, 0,    15, 0, 0});
    tbl.push_back('{1, -8192, 15, 0, 0, -8192, 0, 0});
    tbl.push_back('{1,  8191, 15, 0, 0,  8191, 0, 0});
    tbl.push_back('{1, -8192, 15, 1, 0, -8191, 0, 1});
    tbl.push_back('{1,     5,  0, 0, 0,     0, 1, 0});
    tbl.push_back('{1,    -5,  0, 0, 0,    -1, 0, 1});
    tbl.push_back('{1,    -5,  0, 1, 0,     0, 0, 1});
    tbl.push_back('{1,     0,  0, 1, 0,     0, 0, 0});
    tbl.push_back('{0,    77,  4, 0, 0,     0, 0, 0});
    tbl.push_back('{1,  8191, 13, 0, 0,  8191, 0, 0});
    tbl.push_back('{1,  5000, 12, 0, 0,  4095, 1, 0});
    tbl.push_back('{1, -5000, 12, 0, 0, -4096, 0, 1});
    tbl.push_back('{0,     3,  4, 0, 1, -4096, 0, 0});
    tbl.push_back('{1,   100,  4, 0, 1,    15, 1, 0});
    tbl.push_back('{0,     0,  4, 0, 1,    15, 0, 0});

    in_valid = 0; in = '0; lim = '0; sym = 0; clr = 0; rst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.out",        $signed(out), 0);
    chk("reset.out_valid",  int'(out_valid), 0);
    chk("reset.flags",      int'({pos_sat, neg_sat, sticky_pos, sticky_neg}), 0);
    chk("reset.sat_cnt",    int'(sat_cnt), 0);

    foreach (tbl[i]) begin
      step($sformatf("vec%0d", i), tbl[i].v, tbl[i].x, tbl[i].l, tbl[i].s,
           tbl[i].c, 1'b0, tbl[i].eo, tbl[i].ep, tbl[i].en);
    end

    // counter saturation: 20 back-to-back clamps must stop at the top
    for (int k = 0; k < 20; k++) begin
      auto_step($sformatf("satrun%0d", k), 1'b1, (k % 2) ? -300 : 300, 5, k[0], 1'b0, 1'b0);
    end
    chk("satrun.cnt_held", int'(sat_cnt), CMAX);
    auto_step("satrun.noclamp", 1'b1, 7, 5, 0, 1'b0, 1'b0);

    // clear with a negative clamp in the same cycle, then clear alone
    auto_step("clr_evt", 1'b1, -999, 3, 1, 1'b1, 1'b0);
    auto_step("clr_only", 1'b0, 0, 3, 0, 1'b1, 1'b0);

    // idle gap holds the last value, then limit change takes effect on the next sample
    auto_step("gap0", 1'b1, 21, 6, 0, 1'b0, 1'b0);
    auto_step("gap1", 1'b0, 1000, 2, 0, 1'b0, 1'b0);
    auto_step("gap2", 1'b0, -1000, 2, 0, 1'b0, 1'b0);
    auto_step("gap3", 1'b1, 21, 2, 0, 1'b0, 1'b0);

    // reset mid-stream discards the clamped sample presented with it
    auto_step("pre_rst", 1'b1, 4000, 8, 0, 1'b0, 1'b0);
    auto_step("mid_rst", 1'b1, -4000, 8, 0, 1'b0, 1'b1);
    auto_step("post_rst", 1'b1, 9, 8, 0, 1'b0, 1'b0);

    chk("scoreboard.drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
